fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined CPU.
- Handles forwarding for NUM_SRC operands in the EX stage, with priority EX/MEM over MEM/WB. Register 0 is never forwarded.
- Stalls decode on a load-use hazard for a configurable number of bubble cycles, using a small FSM with a countdown counter.
- Sits beside the ID/EX pipeline register. Drives the ALU operand muxes and the PC / IF-ID write enables and the ID/EX flush.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction (rs, rt, ...).
- LOAD_LAT, 1, bubbles inserted per load-use hazard; range 1..15.
- CNT_W, 4, width of the stall counter; must satisfy 2^CNT_W > LOAD_LAT.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- id_src  in  NUM_SRC*REG_AW  decode-stage source registers; source i in bits [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  per-source valid bit for the decode-stage instruction.
- ex_src  in  NUM_SRC*REG_AW  ID/EX source registers, same packing.
- id_ex_rd  in  REG_AW  ID/EX destination register.
- id_ex_mem_read  in  1  ID/EX instruction is a load.
- ex_mem_rd  in  REG_AW  EX/MEM destination register.
- ex_mem_reg_write  in  1  EX/MEM instruction writes the register file.
- mem_wb_rd  in  REG_AW  MEM/WB destination register.
- mem_wb_reg_write  in  1  MEM/WB instruction writes the register file.
- hold  in  1  global pipeline freeze (cache miss); freezes the FSM.
- flush  in  1  branch/jump flush of IF/ID.
- fwd_sel  out  NUM_SRC*2  per-source mux select: 0 = register file, 1 = MEM/WB, 2 = EX/MEM.
- pc_write  out  1  PC write enable.
- if_id_write  out  1  IF/ID write enable.
- id_ex_bubble  out  1  insert a NOP into ID/EX.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state IDLE, cnt 0, pc_write 1, if_id_write 1, id_ex_bubble 0, fwd_sel all 0.
- Forwarding is combinational, per source i:
  - EX/MEM match: ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == ex_src[i] -> 2.
  - Otherwise MEM/WB match: mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == ex_src[i] -> 1.
  - Otherwise 0.
  - Forwarding does not depend on FSM state or hold.
- Hazard detect (combinational): haz = id_ex_mem_read && id_ex_rd != 0 && for some i, id_src_used[i] && id_src[i] == id_ex_rd.
- FSM states: IDLE, STALL.
  - IDLE, haz && !flush: outputs stall in the same cycle (pc_write=0, if_id_write=0, id_ex_bubble=1). This cycle is the first bubble.
    - If LOAD_LAT == 1, stay in IDLE.
    - Otherwise, when !hold, go to STALL with cnt = LOAD_LAT-1.
  - STALL: outputs stall. Hazard detect is ignored.
    - When !hold: cnt decrements; if cnt == 1, go to IDLE next cycle.
    - When hold: cnt and state are frozen; outputs keep stalling.
  - IDLE with hold: no state change; the stall outputs still follow haz.
  - flush in any state: the next state is IDLE, cnt is set to 0, and no new stall is requested that cycle. Stall outputs are deasserted in the flush cycle (pc_write=1, if_id_write=1) so the redirect can load. flush takes priority over hold.
- Total bubbles per hazard = LOAD_LAT. After the final bubble, the load result is taken via MEM/WB forwarding or from the register file (write-before-read).
- Reset asserted mid-STALL: IDLE on the next edge, with outputs at their reset values.
- fwd_sel must never be 3.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined, adds two outputs, perf_stall_cnt (out 32) and perf_fwd_cnt (out 32). Both are 0 on reset and saturate at 2^32-1.
  - perf_stall_cnt increments on every cycle with id_ex_bubble=1 && !hold.
  - perf_fwd_cnt increments by the number of sources with nonzero fwd_sel on each !hold cycle (0..NUM_SRC).
- When undefined, these ports and their logic are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - fwd_sel_t enum: FWD_REG=0, FWD_MEMWB=1, FWD_EXMEM=2.
  - haz_state_t enum: IDLE, STALL.
  - REG_ZERO constant.
- One natural sub-module: fwd_src_sel, the per-source priority comparator, instantiated NUM_SRC times in a generate loop. The FSM stays in the top level.

Test Plan:
- Forward priority: ex_src[0]=5, ex_mem_rd=5 wr=1, mem_wb_rd=5 wr=1 -> fwd_sel[0]=2. Then ex_mem_reg_write=0 -> fwd_sel[0]=1.
- Register zero: ex_src[1]=0, ex_mem_rd=0 wr=1 -> fwd_sel[1]=0. Load with id_ex_rd=0 -> no stall.
- Load-use, LOAD_LAT=1: id_ex_mem_read=1, id_ex_rd=8, id_src[1]=8 used -> exactly 1 cycle of pc_write=0 and id_ex_bubble=1, then normal operation.
- Load-use, LOAD_LAT=3, hold pulsed 2 cycles mid-stall -> 5 stall cycles total; IDLE afterwards.
- Flush during STALL at cnt=2 -> next cycle IDLE, pc_write=1. A haz coinciding with flush raises no stall.
- Reset in STALL -> next cycle outputs at reset values. With FWD_HAZARD_PERF_EN defined, after the LOAD_LAT=3 scenario perf_stall_cnt=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU hazard/forwarding logic.
//
// Contents:
//   fwd_sel_t   - ALU operand mux select encoding (register file, MEM/WB, EX/MEM)
//   haz_state_t - load-use stall FSM states
//   REG_ZERO    - architectural zero register index, never forwarded or stalled on
package cpu_pkg;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } haz_state_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/fwd_src_sel.sv
// Per-source forwarding priority comparator.
//
// Ports:
//   ex_src           in  REG_AW  source register of the instruction in EX
//   ex_mem_rd        in  REG_AW  EX/MEM destination register
//   ex_mem_reg_write in  1       EX/MEM writes the register file
//   mem_wb_rd        in  REG_AW  MEM/WB destination register
//   mem_wb_reg_write in  1       MEM/WB writes the register file
//   sel              out 2       operand mux select (fwd_sel_t encoding)
module fwd_src_sel
  import cpu_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_src,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_reg_write,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_reg_write,
  output logic [1:0]        sel
);

  logic ex_mem_hit;
  logic mem_wb_hit;

  // The younger result (EX/MEM) wins over the older one (MEM/WB); writes to
  // the zero register are discarded, so they must never be forwarded.
  assign ex_mem_hit = ex_mem_reg_write && (ex_mem_rd != REG_AW'(REG_ZERO))
                      && (ex_mem_rd == ex_src);
  assign mem_wb_hit = mem_wb_reg_write && (mem_wb_rd != REG_AW'(REG_ZERO))
                      && (mem_wb_rd == ex_src);

  always_comb begin
    if (ex_mem_hit)      sel = FWD_EXMEM;
    else if (mem_wb_hit) sel = FWD_MEMWB;
    else                 sel = FWD_REG;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the pipelined CPU.
//
// Forwarding selects, per EX-stage source, between register file, MEM/WB and
// EX/MEM. A load in ID/EX whose destination is read by the decode-stage
// instruction stalls PC and IF/ID and bubbles ID/EX for LOAD_LAT cycles.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   id_src, id_src_used              decode-stage sources (packed, REG_AW each) and valids
//   ex_src                           ID/EX sources, same packing
//   id_ex_rd, id_ex_mem_read         ID/EX destination and load flag
//   ex_mem_rd, ex_mem_reg_write      EX/MEM writeback info
//   mem_wb_rd, mem_wb_reg_write      MEM/WB writeback info
//   hold                             global freeze; freezes the stall FSM
//   flush                            branch/jump redirect; cancels any stall
//   fwd_sel                          per-source 2-bit mux select
//   pc_write, if_id_write            fetch/decode write enables
//   id_ex_bubble                     insert NOP into ID/EX
//
// Optional: define FWD_HAZARD_PERF_EN to add saturating 32-bit counters
//   perf_stall_cnt (bubble cycles) and perf_fwd_cnt (forwarded operands).
module fwd_hazard_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_mem_read,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      ex_mem_reg_write,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic                      mem_wb_reg_write,
  input  logic                      hold,
  input  logic                      flush,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic                      id_ex_bubble
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_fwd_cnt
`endif
);

  haz_state_t       state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             haz;
  logic             stall;

  // One priority comparator per EX-stage source operand.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_sel #(.REG_AW(REG_AW)) u_sel (
      .ex_src           (ex_src[i*REG_AW +: REG_AW]),
      .ex_mem_rd        (ex_mem_rd),
      .ex_mem_reg_write (ex_mem_reg_write),
      .mem_wb_rd        (mem_wb_rd),
      .mem_wb_reg_write (mem_wb_reg_write),
      .sel              (fwd_sel[i*2 +: 2])
    );
  end

  // Load-use hazard: a load to a nonzero register that the decode-stage
  // instruction actually reads through one of its used sources.
  always_comb begin
    haz = 1'b0;
    if (id_ex_mem_read && (id_ex_rd != REG_AW'(REG_ZERO))) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (id_src_used[i] && (id_src[i*REG_AW +: REG_AW] == id_ex_rd)) haz = 1'b1;
      end
    end
  end

  // The detecting cycle is already the first bubble, so STALL only covers the
  // remaining LOAD_LAT-1 bubbles. Flush overrides everything so the redirected
  // fetch can load.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    stall      = 1'b0;
    if (flush) begin
      next_state = IDLE;
      next_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (haz) begin
            stall = 1'b1;
            if ((LOAD_LAT > 1) && !hold) begin
              next_state = STALL;
              next_cnt   = CNT_W'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          if (!hold) begin
            next_cnt = cnt - 1'b1;
            if (cnt == CNT_W'(1)) next_state = IDLE;
          end
        end
        default: begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Stall outputs are held at their reset values while reset is asserted.
  assign pc_write     = !(stall && !rst);
  assign if_id_write  = !(stall && !rst);
  assign id_ex_bubble = stall && !rst;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] fwd_inc;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_inc = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_inc = fwd_inc + 32'(|fwd_sel[i*2 +: 2]);
    end
    fwd_sum = {1'b0, perf_fwd_cnt} + {1'b0, fwd_inc};
  end

  // Both counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else if (!hold) begin
      if (id_ex_bubble && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      perf_fwd_cnt <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [NUM_SRC*REG_AW-1:0] ex_src;
  logic [REG_AW-1:0]         id_ex_rd;
  logic                      id_ex_mem_read;
  logic [REG_AW-1:0]         ex_mem_rd;
  logic                      ex_mem_reg_write;
  logic [REG_AW-1:0]         mem_wb_rd;
  logic                      mem_wb_reg_write;
  logic                      hold;
  logic                      flush;

  logic [NUM_SRC*2-1:0] fwd_sel1, fwd_sel3;
  logic pc_write1, if_id_write1, id_ex_bubble1;
  logic pc_write3, if_id_write3, id_ex_bubble3;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] perf_stall1, perf_fwd1, perf_stall3, perf_fwd3;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Single-bubble instance.
  fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .LOAD_LAT(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_used(id_src_used), .ex_src(ex_src),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd),
    .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_rd(mem_wb_rd),
    .mem_wb_reg_write(mem_wb_reg_write), .hold(hold), .flush(flush),
    .fwd_sel(fwd_sel1), .pc_write(pc_write1), .if_id_write(if_id_write1),
    .id_ex_bubble(id_ex_bubble1)
`ifdef FWD_HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall1), .perf_fwd_cnt(perf_fwd1)
`endif
  );

  // Three-bubble instance sharing the same stimulus.
  fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .LOAD_LAT(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_used(id_src_used), .ex_src(ex_src),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd),
    .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_rd(mem_wb_rd),
    .mem_wb_reg_write(mem_wb_reg_write), .hold(hold), .flush(flush),
    .fwd_sel(fwd_sel3), .pc_write(pc_write3), .if_id_write(if_id_write3),
    .id_ex_bubble(id_ex_bubble3)
`ifdef FWD_HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall3), .perf_fwd_cnt(perf_fwd3)
`endif
  );

  typedef struct {
    logic [4:0] ex_s0, ex_s1, em_rd;
    logic       em_wr;
    logic [4:0] mw_rd;
    logic       mw_wr;
    logic [4:0] id_s0, id_s1;
    logic [1:0] used;
    logic [4:0] ie_rd;
    logic       ie_load;
    logic [1:0] exp_f0, exp_f1;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ex_src           = {v.ex_s1, v.ex_s0};
    ex_mem_rd        = v.em_rd;
    ex_mem_reg_write = v.em_wr;
    mem_wb_rd        = v.mw_rd;
    mem_wb_reg_write = v.mw_wr;
    id_src           = {v.id_s1, v.id_s0};
    id_src_used      = v.used;
    id_ex_rd         = v.ie_rd;
    id_ex_mem_read   = v.ie_load;
  endtask

  task automatic clearInputs();
    id_src = '0; id_src_used = '0; ex_src = '0; id_ex_rd = '0; id_ex_mem_read = 1'b0;
    ex_mem_rd = '0; ex_mem_reg_write = 1'b0; mem_wb_rd = '0; mem_wb_reg_write = 1'b0;
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    clearInputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive a load of r8 read by decode-stage source 1.
  task automatic setHazard();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd8; id_src = {5'd8, 5'd0}; id_src_used = 2'b10;
  endtask

  task automatic clearHazard();
    id_ex_mem_read = 1'b0; id_ex_rd = '0; id_src = '0; id_src_used = '0;
  endtask

  logic hold_pat[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic stall_pat[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    //                ex0 ex1 emrd w mwrd w id0 id1 used ierd ld  f0 f1 st
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'd0, 2'd0, 0};
    vecs[1]  = '{5'd5, 5'd0, 5'd5, 1, 5'd5, 1, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'd2, 2'd0, 0};
    vecs[2]  = '{5'd5, 5'd0, 5'd5, 0, 5'd5, 1, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'd1, 2'd0, 0};
    vecs[3]  = '{5'd3, 5'd0, 5'd0, 1, 5'd0, 1, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'd0, 2'd0, 0};
    vecs[4]  = '{5'd7, 5'd9, 5'd9, 1, 5'd7, 1, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'd1, 2'd2, 0};
    vecs[5]  = '{5'd4, 5'd4, 5'd4, 0, 5'd4, 0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'd0, 2'd0, 0};
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd8, 2'b10, 5'd8, 1, 2'd0, 2'd0, 1};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd8, 2'b01, 5'd8, 1, 2'd0, 2'd0, 0};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, 2'b01, 5'd0, 1, 2'd0, 2'd0, 0};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd8, 5'd0, 2'b01, 5'd8, 0, 2'd0, 2'd0, 0};
    vecs[10] = '{5'd31, 5'd31, 5'd31, 1, 5'd2, 1, 5'd12, 5'd12, 2'b11, 5'd12, 1, 2'd2, 2'd2, 1};

    clearInputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_pc_write", 32'(pc_write3), 32'd1);
    checkOutput("rst_if_id_write", 32'(if_id_write3), 32'd1);
    checkOutput("rst_bubble", 32'(id_ex_bubble3), 32'd0);
    checkOutput("rst_fwd_sel", 32'(fwd_sel3), 32'd0);
    rst = 1'b0;

    // Combinational vectors, judged on the single-bubble instance which
    // never leaves IDLE.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_fwd0", i), 32'(fwd_sel1[1:0]), 32'(vecs[i].exp_f0));
      checkOutput($sformatf("v%0d_fwd1", i), 32'(fwd_sel1[3:2]), 32'(vecs[i].exp_f1));
      checkOutput($sformatf("v%0d_fwd_l3", i), 32'(fwd_sel3), 32'({vecs[i].exp_f1, vecs[i].exp_f0}));
      checkOutput($sformatf("v%0d_pc_write", i), 32'(pc_write1), 32'(!vecs[i].exp_stall));
      checkOutput($sformatf("v%0d_if_id_write", i), 32'(if_id_write1), 32'(!vecs[i].exp_stall));
      checkOutput($sformatf("v%0d_bubble", i), 32'(id_ex_bubble1), 32'(vecs[i].exp_stall));
    end

    // LOAD_LAT=1: one bubble, then back to normal once the load moves on.
    doReset();
    setHazard();
    #1;
    checkOutput("l1_first_pc_write", 32'(pc_write1), 32'd0);
    checkOutput("l1_first_bubble", 32'(id_ex_bubble1), 32'd1);
    @(negedge clk);
    clearHazard();
    #1;
    checkOutput("l1_after_pc_write", 32'(pc_write1), 32'd1);
    checkOutput("l1_after_bubble", 32'(id_ex_bubble1), 32'd0);

    // LOAD_LAT=3 with a two-cycle hold in the middle: five stall cycles.
    doReset();
    setHazard();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) clearHazard();
      hold = hold_pat[c];
      #1;
      checkOutput($sformatf("l3_c%0d_bubble", c), 32'(id_ex_bubble3), 32'(stall_pat[c]));
      checkOutput($sformatf("l3_c%0d_pc_write", c), 32'(pc_write3), 32'(!stall_pat[c]));
    end
    hold = 1'b0;
`ifdef FWD_HAZARD_PERF_EN
    @(negedge clk);
    #1;
    checkOutput("perf_stall_cnt", perf_stall3, 32'd3);
`endif

    // Flush while in STALL (cnt=2): stall released in the flush cycle, IDLE after.
    doReset();
    setHazard();
    @(negedge clk);
    clearHazard();
    #1;
    checkOutput("fl_in_stall_bubble", 32'(id_ex_bubble3), 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("fl_cycle_pc_write", 32'(pc_write3), 32'd1);
    checkOutput("fl_cycle_bubble", 32'(id_ex_bubble3), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("fl_next_pc_write", 32'(pc_write3), 32'd1);
    checkOutput("fl_next_if_id_write", 32'(if_id_write3), 32'd1);

    // Hazard coinciding with flush raises no stall now or later.
    @(negedge clk);
    setHazard();
    flush = 1'b1;
    #1;
    checkOutput("flhaz_pc_write", 32'(pc_write3), 32'd1);
    checkOutput("flhaz_bubble", 32'(id_ex_bubble3), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    clearHazard();
    #1;
    checkOutput("flhaz_next_pc_write", 32'(pc_write3), 32'd1);

    // Reset while in STALL returns to IDLE with reset-valued outputs.
    doReset();
    setHazard();
    @(negedge clk);
    clearHazard();
    #1;
    checkOutput("rs_in_stall_pc_write", 32'(pc_write3), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rs_after_pc_write", 32'(pc_write3), 32'd1);
    checkOutput("rs_after_if_id_write", 32'(if_id_write3), 32'd1);
    checkOutput("rs_after_bubble", 32'(id_ex_bubble3), 32'd0);
    checkOutput("rs_after_fwd_sel", 32'(fwd_sel3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
